// File: rtl/div_pkg.sv
// Shared constants for the restoring-division controller and its subtractor.
// State encoding, default operand width and the divide-by-zero quotient.
package div_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH_DEF-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/subtr.sv
// Shared unsigned subtractor, diff_o = a_i - b_i modulo 2**WIDTH.
// Purely combinational, no handshake.
module subtr #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o
);

  assign diff_o = a_i - b_i;

endmodule

// File: rtl/sub_div_ctrl.sv
// Unsigned restoring divider, one quotient bit per cycle: done_o 9 cycles after accept (1 for /0).
// Start accepted only while ready_o is high; starts at any other time are dropped.
import div_pkg::*;

module sub_div_ctrl #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  state_e             state_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dz_q;
  logic [WIDTH-1:0]   res_quo_q;
  logic [WIDTH-1:0]   res_rem_q;
  logic               res_dz_q;

  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   diff;
  logic               take;

  assign shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  subtr #(.WIDTH(WIDTH)) u_subtr (
    .a_i    (shifted),
    .b_i    (dvs_q),
    .diff_o (diff)
  );

  // A set msb means the true 9-bit partial remainder exceeds any divisor.
  assign take = rem_q[WIDTH-1] | (shifted >= dvs_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      res_dz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!abort_i && start_i) begin
            dvs_q    <= divisor_i;
            cnt_q    <= CNT_W'(WIDTH - 1);
            res_dz_q <= 1'b0;
            if (divisor_i == '0) begin
              quo_q   <= WIDTH'(DIV0_QUOTIENT);
              rem_q   <= dividend_i;
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              quo_q   <= dividend_i;
              rem_q   <= '0;
              dz_q    <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else begin
            rem_q <= take ? diff : shifted;
            quo_q <= {quo_q[WIDTH-2:0], take};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          // Results are committed only if the DONE cycle was not flushed.
          if (!abort_i) begin
            res_quo_q <= quo_q;
            res_rem_q <= rem_q;
            res_dz_q  <= dz_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o       = (state_q == IDLE);
  assign busy_o        = (state_q == CALC) || (state_q == DONE);
  assign done_o        = (state_q == DONE) && !abort_i;
  assign quotient_o    = (state_q == DONE) ? quo_q : res_quo_q;
  assign remainder_o   = (state_q == DONE) ? rem_q : res_rem_q;
  assign div_by_zero_o = (state_q == DONE) ? dz_q  : res_dz_q;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// Bench for sub_div_ctrl: vector table plus abort, ignored-start and mid-op reset sequences.
// Expected results are queued at accept and checked when done_o fires.
module tb_sub_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       abort_i;
  logic [7:0] dividend_i;
  logic [7:0] divisor_i;
  logic       ready_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] quotient_o;
  logic [7:0] remainder_o;
  logic       div_by_zero_o;

  sub_div_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         acc;
    int         lat;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient_o, e.q);
        chk("remainder", remainder_o, e.r);
        chk("div_by_zero", div_by_zero_o, e.dz);
        chk("done_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_ready(input string tag);
    int k = 0;
    while (ready_o !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_ready"}, ready_o, 1);
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r, input logic dz);
    exp_t e;
    @(posedge clk); #1;
    wait_ready("pre");
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    e.q = q; e.r = r; e.dz = dz; e.acc = cyc; e.lat = (b == 0) ? 1 : 9;
    sb.push_back(e);
    @(posedge clk); #1;
    start_i    = 1'b0;
    dividend_i = 8'($urandom);
    divisor_i  = 8'($urandom);
    chk("ready_drop", ready_o, 0);
    chk("busy_set", busy_o, 1);
    chk("dz_at_t1", div_by_zero_o, (b == 0) ? 1 : 0);
    wait_ready("post");
    chk("ready_latency", cyc - e.acc, (b == 0) ? 2 : 10);
    chk("held_quotient", quotient_o, q);
    chk("held_remainder", remainder_o, r);
  endtask

  vec_t vt[8];
  int   n0;
  exp_t ex;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    #12;
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_quotient", quotient_o, 0);
    chk("rst_remainder", remainder_o, 0);
    chk("rst_dz", div_by_zero_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    vt[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vt[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vt[2] = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0};
    vt[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vt[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vt[5] = '{8'd129, 8'd128, 8'd1,   8'd1,   1'b0};
    vt[6] = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1};
    vt[7] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
    for (int i = 0; i < 8; i++) do_div(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz);

    // Abort during CALC: previous 3/0 must survive, restart at T+6.
    @(posedge clk); #1;
    dividend_i = 8'd200; divisor_i = 8'd7; start_i = 1'b1;
    n0 = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_at_t5", cyc - n0, 5);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_ready", ready_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_quotient", quotient_o, 3);
    chk("abort_remainder", remainder_o, 0);
    dividend_i = 8'd30; divisor_i = 8'd4; start_i = 1'b1;
    ex.q = 8'd7; ex.r = 8'd2; ex.dz = 1'b0; ex.acc = cyc; ex.lat = 9;
    sb.push_back(ex);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("restart_accepted", ready_o, 0);
    wait_ready("restart");

    // Start during CALC must be ignored.
    @(posedge clk); #1;
    dividend_i = 8'd100; divisor_i = 8'd9; start_i = 1'b1;
    ex.q = 8'd11; ex.r = 8'd1; ex.dz = 1'b0; ex.acc = cyc; ex.lat = 9;
    sb.push_back(ex);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dividend_i = 8'd50; divisor_i = 8'd5; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_ready("ignored");
    repeat (12) @(posedge clk);
    #1;
    chk("ignored_quotient", quotient_o, 11);

    // Reset mid-division.
    @(posedge clk); #1;
    dividend_i = 8'd200; divisor_i = 8'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_quotient", quotient_o, 0);
    chk("mid_rst_remainder", remainder_o, 0);
    chk("mid_rst_dz", div_by_zero_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_div(8'd128, 8'd16, 8'd8, 8'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_div_ctrl.md
Name: sub_div_ctrl

Overview:
- Sequential controller that drives the shared 8-bit subtractor (`subtr`) through an unsigned restoring-division sequence, one quotient bit per cycle.
- Serves the processor's DIV/DIVU path: the execute stage issues a start pulse and stalls until `done_o`.
- Quotient and remainder are registered and held for the HI/LO writeback.

Parameters:
- WIDTH, 8, operand/result width; must match the `subtr` instance width.
- CNT_W, 3, iteration counter width (clog2(WIDTH)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request a division; sampled only in IDLE.
- abort_i  input  1  synchronous cancel (pipeline flush); no `done_o` produced.
- dividend_i  input  WIDTH  unsigned dividend, sampled with `start_i`.
- divisor_i  input  WIDTH  unsigned divisor, sampled with `start_i`.
- ready_o  output  1  high only in IDLE; start is accepted only when high.
- busy_o  output  1  high in CALC and DONE.
- done_o  output  1  single-cycle pulse; results valid from this cycle.
- quotient_o  output  WIDTH  registered quotient, held until next accepted start.
- remainder_o  output  WIDTH  registered remainder, held until next accepted start.
- div_by_zero_o  output  1  registered; set with `done_o` when divisor was 0, cleared on next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - ready_o=1, busy_o=0, done_o=0.
  - quotient_o, remainder_o, div_by_zero_o = 0.
  - Internal working registers = 0.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1 at cycle T (accept):
  - Latch divisor to dvs_r.
  - Set working regs rem_r=0, quo_r=dividend_i, cnt_r=WIDTH-1.
  - Clear div_by_zero_o.
- Divisor zero: if divisor_i==0 on accept, go directly to DONE at T+1 with quotient_o=all ones (0xFF), remainder_o=dividend_i, div_by_zero_o=1.
- Divisor nonzero: go to CALC at T+1.
- CALC, each cycle:
  - shifted = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]}; msb = rem_r[WIDTH-1].
  - `subtr` computes diff = shifted - dvs_r.
  - If msb=1 or shifted >= dvs_r: rem_r=diff, quo_r={quo_r[WIDTH-2:0],1}.
  - Else: rem_r=shifted, quo_r={quo_r[WIDTH-2:0],0}.
  - The 9-bit wrap is handled by the msb term: the 8-bit diff is exact whenever msb=1.
  - cnt_r decrements; when cnt_r==0 after the update, go to DONE.
  - CALC occupies exactly WIDTH cycles (T+1..T+8).
- DONE (T+9 for nonzero divisor):
  - done_o=1 for this cycle only.
  - quotient_o and remainder_o are valid (loaded on entry to DONE).
  - Next state IDLE unconditionally; a start_i in DONE is ignored.
- Latency: accept to done_o = 9 cycles (nonzero divisor), 1 cycle (zero divisor). Throughput is one division per 10 cycles.
- start_i while not IDLE: ignored; no operand latch, no effect on the operation in flight.
- abort_i:
  - In CALC or DONE: next state IDLE, done_o suppressed (forced 0 that cycle), quotient_o/remainder_o keep previous values.
  - In IDLE: abort_i has priority over start_i.
- Reset mid-operation: immediate return to reset values; the partial result is lost.
- Operands are unsigned only; signed DIV sign handling lives in the execute stage.

Decomposition:
- Shared package/header div_pkg:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - WIDTH default.
  - DIV0_QUOTIENT constant (all ones).
- Sub-module: one instance of the existing `subtr` for the trial subtraction. The compare (shifted >= dvs_r) stays in this block.

Test Plan:
- 200/7, start at T: ready_o drops at T+1; done_o=1 only at T+9; quotient_o=28, remainder_o=4, div_by_zero_o=0; ready_o=1 at T+10.
- 255/1 → 255, 0. Then 3/10 → 0, 3. Then 255/255 → 1, 0. Each with 9-cycle latency.
- 5/0 → done_o at T+1; quotient_o=0xFF, remainder_o=5, div_by_zero_o=1. Next accepted start (9/3) clears div_by_zero_o and yields 3, 0.
- 100/9 started; start_i with 50/5 at T+4 is ignored → result 11, 1 at T+9; no second done_o follows.
- abort_i at T+5 during 200/7 (previous result 3, 0 held) → IDLE at T+6; no done_o; outputs still 3, 0; new start accepted at T+6.
- rst_n low at T+4 mid-division → all outputs 0 and ready_o=1 asynchronously. After release, 128/16 → 8, 0 with normal latency.
